// File: rtl/ghash_pkg.sv
// Shared constants for the GHASH sequencer and datapath: operand-select
// encodings, controller states and block size.
package ghash_pkg;

  localparam logic [1:0] SEL_AAD = 2'b00;
  localparam logic [1:0] SEL_CT  = 2'b01;
  localparam logic [1:0] SEL_LEN = 2'b10;

  // A GHASH block is 128 bits, so block counts become bit lengths via << 7.
  localparam int BLK_BITS_LOG2 = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_AAD,
    ST_CT,
    ST_LEN,
    ST_MUL,
    ST_FIN
  } state_t;

endpackage

// File: rtl/ghash_seq_ctrl_if.sv
// Control bundle between the GHASH sequencer, the upstream block source and
// the GHASH datapath (operand mux, Y register, multiplier).
interface ghash_seq_ctrl_if #(
  parameter int LEN_W = 32
);
  // in_valid/in_ready: a block moves only in a cycle where both are 1; the
  // source holds in_valid and its data until then, and in_ready never
  // depends on in_valid.
  logic             start;
  logic [LEN_W-1:0] aad_blocks;
  logic [LEN_W-1:0] ct_blocks;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mux_sel;
  logic [127:0]     len_blk;
  logic             y_clr;
  logic             mul_start;
  logic             mul_done;
  logic             y_en;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, aad_blocks, ct_blocks, in_valid, mul_done,
    output in_ready, mux_sel, len_blk, y_clr, mul_start, y_en, busy, done, err
  );

  modport slave (
    output start, aad_blocks, ct_blocks, in_valid, mul_done,
    input  in_ready, mux_sel, len_blk, y_clr, mul_start, y_en, busy, done, err
  );

endinterface

// File: rtl/ghash_blk_cnt.sv
// Loadable block down-counter; zero flags that no blocks of this kind remain.
module ghash_blk_cnt #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LEN_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - LEN_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ghash_seq_ctrl.sv
// GHASH sequencer: clears Y, then issues one multiply per AAD block, per
// ciphertext block and finally for the length block it builds itself.
module ghash_seq_ctrl
  import ghash_pkg::*;
#(
  parameter int LEN_W  = 32,
  parameter int MUL_TO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  ghash_seq_ctrl_if.master  bus,
  output state_t            dbg_state
);

  state_t       state, nxt;
  logic         aad_zero, ct_zero;
  logic         len_sent, err_q;
  logic [127:0] len_q;
  logic [1:0]   phase_sel;
  logic         accept, to_hit;
  logic         in_ready_c, y_clr_c, mul_start_c, y_en_c, done_c;
  logic [1:0]   mux_sel_c;

  assign accept = (state == ST_IDLE) && bus.start;

  ghash_blk_cnt #(.LEN_W(LEN_W)) u_aad_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (bus.aad_blocks),
    .dec      ((state == ST_AAD) && bus.in_valid),
    .zero     (aad_zero)
  );

  ghash_blk_cnt #(.LEN_W(LEN_W)) u_ct_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (bus.ct_blocks),
    .dec      ((state == ST_CT) && bus.in_valid),
    .zero     (ct_zero)
  );

  // to_hit fires in the last permitted MUL cycle when mul_done is still absent.
  if (MUL_TO > 0) begin : g_to
    logic [31:0] to_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               to_cnt <= '0;
      else if (state != ST_MUL) to_cnt <= '0;
      else                      to_cnt <= to_cnt + 32'd1;
    end
    assign to_hit = (state == ST_MUL) && !bus.mul_done && (to_cnt == 32'(MUL_TO - 1));
  end else begin : g_no_to
    assign to_hit = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (bus.start) nxt = ST_CLR;
      ST_CLR:  nxt = !aad_zero ? ST_AAD : (!ct_zero ? ST_CT : ST_LEN);
      ST_AAD,
      ST_CT:   if (bus.in_valid) nxt = ST_MUL;
      ST_LEN:  nxt = ST_MUL;
      ST_MUL: begin
        if (bus.mul_done) begin
          if (!aad_zero)     nxt = ST_AAD;
          else if (!ct_zero) nxt = ST_CT;
          else if (!len_sent) nxt = ST_LEN;
          else               nxt = ST_FIN;
        end else if (to_hit) begin
          nxt = ST_IDLE;
        end
      end
      ST_FIN:  nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    mux_sel_c   = SEL_AAD;
    y_clr_c     = 1'b0;
    mul_start_c = 1'b0;
    y_en_c      = 1'b0;
    done_c      = 1'b0;
    case (state)
      ST_CLR: y_clr_c = 1'b1;
      ST_AAD: begin
        in_ready_c  = 1'b1;
        mux_sel_c   = SEL_AAD;
        mul_start_c = bus.in_valid;
      end
      ST_CT: begin
        in_ready_c  = 1'b1;
        mux_sel_c   = SEL_CT;
        mul_start_c = bus.in_valid;
      end
      ST_LEN: begin
        mux_sel_c   = SEL_LEN;
        mul_start_c = 1'b1;
      end
      ST_MUL: begin
        mux_sel_c = phase_sel;
        y_en_c    = bus.mul_done;
      end
      ST_FIN:  done_c = 1'b1;
      default: ;
    endcase
  end

  // phase_sel keeps the operand select stable while the multiplier is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      len_sent  <= 1'b0;
      err_q     <= 1'b0;
      phase_sel <= SEL_AAD;
    end else begin
      if (accept) begin
        len_q    <= {64'(bus.aad_blocks) << BLK_BITS_LOG2,
                     64'(bus.ct_blocks)  << BLK_BITS_LOG2};
        len_sent <= 1'b0;
        err_q    <= 1'b0;
      end
      if (state == ST_LEN) len_sent <= 1'b1;
      if (mul_start_c)     phase_sel <= mux_sel_c;
      if (to_hit)          err_q <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mux_sel   = mux_sel_c;
  assign bus.len_blk   = len_q;
  assign bus.y_clr     = y_clr_c;
  assign bus.mul_start = mul_start_c;
  assign bus.y_en      = y_en_c;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_c;
  assign bus.err       = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ghash_seq_ctrl.sv
// Bench for ghash_seq_ctrl: table of whole messages against a latency-L
// multiplier model, plus hand sequences for reset, ignored start and timeout.
module tb_ghash_seq_ctrl;
  import ghash_pkg::*;

  typedef struct {
    int           aad;
    int           ct;
    int           lat;
    int           stall;
    bit           poke;
    int           exp_nmul;
    int           exp_cyc;
    logic [31:0]  exp_seq;
    logic [127:0] exp_len;
  } vec_t;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  ghash_seq_ctrl_if #(.LEN_W(32)) bus ();

  ghash_seq_ctrl #(.LEN_W(32), .MUL_TO(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc, n_mul, n_yen, n_clr, n_done, done_cyc, viol;
  int          pend, lat, stall, wait_cnt;
  bit          poke, poked, respond;
  logic [31:0] seq;
  vec_t        tab[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " in_ready"},  bus.in_ready, 0);
    check({tag, " mux_sel"},   bus.mux_sel, 0);
    check({tag, " len_blk"},   bus.len_blk, 0);
    check({tag, " strobes"},   {bus.y_clr, bus.mul_start, bus.y_en, bus.done}, 0);
    check({tag, " busy_err"},  {bus.busy, bus.err}, 0);
    check({tag, " state"},     dbg_state, ST_IDLE);
  endtask

  // Accepts a message in the current cycle; returns in the CLR cycle (cyc=1).
  task automatic begin_msg(input int aad, input int ct, input int l, input int st,
                           input bit pk, input bit rsp);
    cyc = 0; n_mul = 0; n_yen = 0; n_clr = 0; n_done = 0; done_cyc = -1; viol = 0;
    seq = 0; pend = 0; wait_cnt = 0; poked = 0;
    lat = l; stall = st; poke = pk; respond = rsp;
    bus.aad_blocks = aad;
    bus.ct_blocks  = ct;
    bus.in_valid   = 1'b0;
    bus.mul_done   = 1'b0;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
  endtask

  // One clock cycle: drive source and multiplier model, sample, advance.
  task automatic step();
    if (pend > 0) begin
      pend--;
      bus.mul_done = (pend == 0) && respond;
    end else begin
      bus.mul_done = 1'b0;
    end
    if (stall == 0) begin
      bus.in_valid = 1'b1;
    end else if (bus.in_ready && wait_cnt < stall) begin
      bus.in_valid = 1'b0;
      wait_cnt++;
    end else begin
      bus.in_valid = bus.in_ready;
    end
    if (poke && dbg_state == ST_MUL && !poked) begin
      bus.start = 1'b1; bus.aad_blocks = 7; bus.ct_blocks = 7; poked = 1;
    end else if (poke && dbg_state == ST_FIN) begin
      bus.start = 1'b1;
    end else begin
      bus.start = 1'b0;
    end
    #1;
    if (bus.mul_start) begin
      n_mul++;
      seq = (seq << 2) | 32'(bus.mux_sel);
      if (pend > 0) viol++;
      if (!bus.in_valid && bus.mux_sel != SEL_LEN) viol++;
      pend = lat;
      wait_cnt = 0;
    end
    if (bus.y_en) begin
      n_yen++;
      if (!bus.mul_done) viol++;
    end
    if (bus.y_clr) n_clr++;
    if (bus.done) begin
      n_done++;
      if (n_done == 1) done_cyc = cyc;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    begin_msg(v.aad, v.ct, v.lat, v.stall, v.poke, 1'b1);
    while (n_done == 0 && cyc < 400) step();
    bus.start = 1'b0;
    check({tag, " done_cnt"}, n_done, 1);
    check({tag, " done_cyc"}, done_cyc, v.exp_cyc);
    check({tag, " mul_cnt"},  n_mul, v.exp_nmul);
    check({tag, " yen_cnt"},  n_yen, v.exp_nmul);
    check({tag, " clr_cnt"},  n_clr, 1);
    check({tag, " sel_seq"},  seq, v.exp_seq);
    check({tag, " len_blk"},  bus.len_blk, v.exp_len);
    check({tag, " protocol"}, viol, 0);
    check({tag, " err"},      bus.err, 0);
    check({tag, " idle"},     {bus.busy, bus.done}, 0);
    check({tag, " state"},    dbg_state, ST_IDLE);
  endtask

  initial begin
    vec_t v;
    tab[0] = '{2, 3, 4, 0, 1'b0, 6, 32, 32'h056, {64'd256, 64'd384}};
    tab[1] = '{0, 0, 4, 0, 1'b0, 1,  7, 32'h2,   128'd0};
    tab[2] = '{1, 2, 4, 3, 1'b0, 4, 31, 32'h16,  {64'd128, 64'd256}};
    tab[3] = '{1, 1, 4, 0, 1'b1, 3, 17, 32'h6,   {64'd128, 64'd128}};
    tab[4] = '{1, 0, 8, 0, 1'b0, 2, 20, 32'h2,   {64'd128, 64'd0}};
    tab[5] = '{0, 2, 1, 0, 1'b0, 3,  8, 32'h16,  {64'd0, 64'd256}};

    bus.start = 1'b0; bus.aad_blocks = '0; bus.ct_blocks = '0;
    bus.in_valid = 1'b0; bus.mul_done = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_quiet("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec($sformatf("v%0d", i), tab[i]);

    // Asynchronous reset in the MUL of the second block.
    begin_msg(2, 1, 4, 0, 1'b0, 1'b1);
    while (cyc < 9) step();
    check("rst pre_state", dbg_state, ST_MUL);
    check("rst pre_mul",   n_mul, 2);
    #1 rst_n = 1'b0;
    #1 check_quiet("rst_mid");
    pend = 0; bus.mul_done = 1'b0; bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rst no_done", bus.done, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    v = tab[3];
    v.poke = 1'b0;
    run_vec("post_rst", v);

    // Multiplier never answers: timeout after 8 MUL cycles.
    begin_msg(1, 0, 4, 0, 1'b0, 1'b0);
    while (cyc < 10) step();
    check("to last_mul_state", dbg_state, ST_MUL);
    check("to err_early",      bus.err, 0);
    step();
    check("to state", dbg_state, ST_IDLE);
    check("to err",   bus.err, 1);
    check("to busy",  bus.busy, 0);
    repeat (3) step();
    check("to err_sticky", bus.err, 1);
    check("to no_done",    n_done, 0);
    check("to mul_cnt",    n_mul, 1);
    run_vec("after_to", tab[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
